// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - round-robin frame scheduler feeding the UDP TX encoder with fixed-length payloads
module udp_tx_scheduler #(
    parameter int N_SRC      = 4,
    parameter int IFG_CYCLES = 12,
    parameter int IDX_W      = $clog2(N_SRC)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 enable_i,
    input  logic [15:0]          payload_bytes_i,
    input  logic [N_SRC*16-1:0]  src_port_i,
    input  logic [N_SRC*8-1:0]   s_tdata_i,
    input  logic [N_SRC-1:0]     s_tvalid_i,
    input  logic [N_SRC-1:0]     s_tlast_i,
    output logic [N_SRC-1:0]     s_tready_o,
    output logic [7:0]           m_tdata_o,
    output logic                 m_tvalid_o,
    output logic                 m_tlast_o,
    input  logic                 m_tready_i,
    output logic [15:0]          m_port_o,
    output logic [IDX_W-1:0]     m_grant_o,
    output logic                 busy_o,
    output logic [15:0]          pad_cnt_o,
    output logic [15:0]          trunc_cnt_o
);

    typedef enum logic [2:0] {IDLE, SEND, PAD, DRAIN, GAP} state_t;

    localparam logic [15:0] GAP_LAST  = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
    localparam state_t      AFTER_EOF = (IFG_CYCLES > 0) ? GAP : IDLE;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [15:0]      len;
    logic [15:0]      cnt;
    logic [15:0]      gap_cnt;

    logic [7:0]       src_data [N_SRC];
    logic [15:0]      src_port [N_SRC];
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] next_ptr;
    logic             g_valid, g_last, is_last, gap_done, do_grant;

    always_comb begin
        for (int j = 0; j < N_SRC; j++) begin
            src_data[j] = s_tdata_i[8*j +: 8];
            src_port[j] = src_port_i[16*j +: 16];
        end
    end

    // Lowest requester at or above ptr wins; if none, wrap to the lowest requester overall.
    always_comb begin
        pick = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (s_tvalid_i[j]) pick = IDX_W'(j);
        end
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (s_tvalid_i[j] && (j >= int'(ptr))) pick = IDX_W'(j);
        end
    end

    assign g_valid  = s_tvalid_i[m_grant_o];
    assign g_last   = s_tlast_i[m_grant_o];
    assign is_last  = (cnt == len - 16'd1);
    assign gap_done = (gap_cnt == GAP_LAST);
    assign next_ptr = (m_grant_o == IDX_W'(N_SRC - 1)) ? '0 : m_grant_o + 1'b1;
    // The final GAP cycle doubles as arbitration so back-to-back frames sit exactly IFG_CYCLES idle clocks apart.
    assign do_grant = enable_i && (payload_bytes_i != 16'd0) && (|s_tvalid_i)
                      && ((state == IDLE) || ((state == GAP) && gap_done));
    assign busy_o   = (state != IDLE);

    always_comb begin
        m_tvalid_o = 1'b0;
        m_tdata_o  = 8'd0;
        m_tlast_o  = 1'b0;
        s_tready_o = '0;
        case (state)
            SEND: begin
                m_tvalid_o            = g_valid;
                m_tdata_o             = src_data[m_grant_o];
                m_tlast_o             = is_last;
                s_tready_o[m_grant_o] = m_tready_i;
            end
            PAD: begin
                m_tvalid_o = 1'b1;
                m_tlast_o  = is_last;
            end
            DRAIN: s_tready_o[m_grant_o] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            ptr         <= '0;
            len         <= 16'd0;
            cnt         <= 16'd0;
            gap_cnt     <= 16'd0;
            m_port_o    <= 16'd0;
            m_grant_o   <= '0;
            pad_cnt_o   <= 16'd0;
            trunc_cnt_o <= 16'd0;
        end else if (do_grant) begin
            state     <= SEND;
            m_grant_o <= pick;
            m_port_o  <= src_port[pick];
            len       <= payload_bytes_i;
            cnt       <= 16'd0;
        end else begin
            case (state)
                SEND: if (g_valid && m_tready_i) begin
                    cnt <= cnt + 16'd1;
                    if (is_last) begin
                        ptr     <= next_ptr;
                        gap_cnt <= 16'd0;
                        state   <= g_last ? AFTER_EOF : DRAIN;
                        if (!g_last && trunc_cnt_o != 16'hFFFF) trunc_cnt_o <= trunc_cnt_o + 16'd1;
                    end else if (g_last) begin
                        state <= PAD;
                        if (pad_cnt_o != 16'hFFFF) pad_cnt_o <= pad_cnt_o + 16'd1;
                    end
                end
                PAD: if (m_tready_i) begin
                    cnt <= cnt + 16'd1;
                    if (is_last) begin
                        ptr     <= next_ptr;
                        gap_cnt <= 16'd0;
                        state   <= AFTER_EOF;
                    end
                end
                DRAIN: if (g_valid && g_last) begin
                    gap_cnt <= 16'd0;
                    state   <= AFTER_EOF;
                end
                GAP: begin
                    if (gap_done) state <= IDLE;
                    else          gap_cnt <= gap_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
